// File: rtl/cpu_pkg.sv
// Shared core definitions: instruction encoding, opcode constants and the
// fetch-stage state encoding.
package cpu_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 7;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 7'b0000000;
    localparam logic [OPCODE_W-1:0] OP_HLT  = 7'b0000001;
    localparam logic [OPCODE_W-1:0] OP_INC  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 7'b0010001;
    localparam logic [OPCODE_W-1:0] OP_IADD = 7'b0100000;
    localparam logic [OPCODE_W-1:0] OP_LDD  = 7'b0100010;
    localparam logic [OPCODE_W-1:0] OP_STD  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_LDM  = 7'b0110101;

    localparam int unsigned RST_VEC_LO = 0;
    localparam int unsigned RST_VEC_HI = 1;

    typedef enum logic [1:0] {
        VEC_LO    = 2'd0,
        VEC_HI    = 2'd1,
        FETCH     = 2'd2,
        FETCH_IMM = 2'd3
    } fetch_state_e;

    // Opcodes followed by a 16-bit immediate word
    function automatic logic is_two_word(input logic [OPCODE_W-1:0] opcode);
        case (opcode)
            OP_IADD, OP_LDM, OP_LDD, OP_STD: is_two_word = 1'b1;
            default:                         is_two_word = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: reset-vector load, PC, two-word assembly and the
// IF/ID register, with redirect > stall > advance priority.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int ADDR_W  = 20,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [INSTR_W-1:0] if_id_imm,
    output logic [PC_W-1:0]    if_id_pc_next
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_e       state_r, state_s;
    logic [PC_W-1:0]    pc_r, pc_s;
    logic [INSTR_W-1:0] held_r, held_s;
    logic               valid_r, valid_s;
    logic [INSTR_W-1:0] instr_r, instr_s;
    logic [INSTR_W-1:0] imm_r, imm_s;
    logic [PC_W-1:0]    pc_next_r, pc_next_s;
    logic [PC_W-1:0]    pc_inc_s;
    logic               two_word_s;

    assign pc_inc_s   = pc_r + PC_ONE;
    assign two_word_s = is_two_word(imem_rdata[INSTR_W-1 -: OPCODE_W]);

    // Instruction-memory address selection
    always_comb begin
        case (state_r)
            VEC_LO:  imem_addr = ADDR_W'(RST_VEC_LO);
            VEC_HI:  imem_addr = ADDR_W'(RST_VEC_HI);
            default: imem_addr = pc_r[ADDR_W-1:0];
        endcase
    end

    // Next-state, PC and IF/ID update logic
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        held_s    = held_r;
        valid_s   = valid_r;
        instr_s   = instr_r;
        imm_s     = imm_r;
        pc_next_s = pc_next_r;
        case (state_r)
            VEC_LO: begin
                pc_s    = {pc_r[PC_W-1:16], imem_rdata};
                valid_s = 1'b0;
                state_s = VEC_HI;
            end
            VEC_HI: begin
                pc_s    = {imem_rdata, pc_r[15:0]};
                valid_s = 1'b0;
                state_s = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_s    = redirect_pc;
                    valid_s = 1'b0;
                    state_s = FETCH;
                end else if (stall) begin
                    state_s = state_r;
                end else if (two_word_s) begin
                    held_s  = imem_rdata;
                    pc_s    = pc_inc_s;
                    valid_s = 1'b0;
                    state_s = FETCH_IMM;
                end else begin
                    valid_s   = 1'b1;
                    instr_s   = imem_rdata;
                    imm_s     = {INSTR_W{1'b0}};
                    pc_next_s = pc_inc_s;
                    pc_s      = pc_inc_s;
                end
            end
            FETCH_IMM: begin
                // A redirect here drops the half-assembled opcode word
                if (redirect_valid) begin
                    pc_s    = redirect_pc;
                    valid_s = 1'b0;
                    state_s = FETCH;
                end else if (stall) begin
                    state_s = state_r;
                end else begin
                    valid_s   = 1'b1;
                    instr_s   = held_r;
                    imm_s     = imem_rdata;
                    pc_next_s = pc_inc_s;
                    pc_s      = pc_inc_s;
                    state_s   = FETCH;
                end
            end
            default: begin
                state_s = VEC_LO;
                valid_s = 1'b0;
            end
        endcase
    end

    // State, PC, held word and IF/ID registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= VEC_LO;
            pc_r      <= {PC_W{1'b0}};
            held_r    <= {INSTR_W{1'b0}};
            valid_r   <= 1'b0;
            instr_r   <= {INSTR_W{1'b0}};
            imm_r     <= {INSTR_W{1'b0}};
            pc_next_r <= {PC_W{1'b0}};
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            held_r    <= held_s;
            valid_r   <= valid_s;
            instr_r   <= instr_s;
            imm_r     <= imm_s;
            pc_next_r <= pc_next_s;
        end
    end

    assign if_id_valid   = valid_r;
    assign if_id_instr   = instr_r;
    assign if_id_imm     = imm_r;
    assign if_id_pc_next = pc_next_r;

endmodule
